// File: rtl/mystic_boot_ctrl.sv
// UART boot loader: receives a MAGIC/length/data/checksum frame, writes the data into
// main memory and answers ACK/NAK. Optional inter-byte timeout: MYSTIC_BOOT_TIMEOUT_EN.
module mystic_boot_ctrl #(
  parameter int          ADDR_W      = 18,
  parameter logic [7:0]  MAGIC       = 8'hA5,
  parameter logic [7:0]  ACK         = 8'h06,
  parameter logic [7:0]  NAK         = 8'h15,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_done_tick_i,
  output logic [7:0]        tx_din_o,
  output logic              tx_start_o,
  input  logic              tx_done_tick_i,
  output logic [ADDR_W-1:0] uart_mem_addr,
  output logic [7:0]        uart_mem_dout,
  output logic              uart_mem_we,
  output logic              disable_core_n,
  output logic              boot_err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN2, S_LEN1, S_LEN0, S_DATA, S_CHK, S_RESP, S_RUN
  } state_t;

  // Largest accepted frame fills the whole address space.
  localparam logic [24:0] MAX_LEN = 25'(1) << ADDR_W;

  state_t              state_reg, state_next;
  logic [23:0]         len_reg;
  logic [23:0]         idx_reg;
  logic [7:0]          sum_reg;
  logic                ack_reg;
  logic [7:0]          tx_din_reg;
  logic                tx_start_reg;
  logic                mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [7:0]          mem_dout_reg;
  logic                boot_err_reg;

  logic [23:0]         len_full;
  logic                len_over;
  logic                last_data;
  logic                resp_ack;
  logic                enter_len2;
  logic                enter_resp;
  logic                timeout_fire;

  assign len_full   = {len_reg[23:8], rx_data_i};
  assign len_over   = {1'b0, len_full} > MAX_LEN;
  assign last_data  = (idx_reg == len_reg - 24'd1);
  assign resp_ack   = (state_reg == S_CHK) && (rx_data_i == sum_reg);
  assign enter_len2 = (state_next == S_LEN2) && (state_reg != S_LEN2);
  assign enter_resp = (state_next == S_RESP) && (state_reg != S_RESP);

`ifdef MYSTIC_BOOT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             in_frame;

  assign in_frame = (state_reg == S_LEN2) || (state_reg == S_LEN1) ||
                    (state_reg == S_LEN0) || (state_reg == S_DATA) ||
                    (state_reg == S_CHK);
  // A byte arriving in the expiry cycle wins over the timeout.
  assign timeout_fire = in_frame && !rx_done_tick_i &&
                        (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || rx_done_tick_i || (state_next != state_reg)) begin
      cnt_reg <= '0;
    end else if (cnt_reg != CNT_W'(TIMEOUT_CYC - 1)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end
`else
  logic unused_timeout_cyc;

  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout_fire       = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (rx_done_tick_i && rx_data_i == MAGIC) state_next = S_LEN2;
      S_LEN2: if (rx_done_tick_i) state_next = S_LEN1;
      S_LEN1: if (rx_done_tick_i) state_next = S_LEN0;
      S_LEN0: begin
        if (rx_done_tick_i) begin
          if (len_full == 24'd0) begin
            state_next = S_CHK;
          end else if (len_over) begin
            state_next = S_RESP;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: if (rx_done_tick_i && last_data) state_next = S_CHK;
      S_CHK:  if (rx_done_tick_i) state_next = S_RESP;
      S_RESP: if (tx_done_tick_i) state_next = ack_reg ? S_RUN : S_IDLE;
      S_RUN:  if (rx_done_tick_i && rx_data_i == MAGIC) state_next = S_LEN2;
      default: state_next = S_IDLE;
    endcase
    if (timeout_fire) begin
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_reg      <= '0;
      idx_reg      <= '0;
      sum_reg      <= '0;
      ack_reg      <= 1'b0;
      tx_din_reg   <= '0;
      tx_start_reg <= 1'b0;
      mem_we_reg   <= 1'b0;
      mem_addr_reg <= '0;
      mem_dout_reg <= '0;
      boot_err_reg <= 1'b0;
    end else begin
      mem_we_reg   <= 1'b0;
      tx_start_reg <= 1'b0;
      if (enter_len2) begin
        sum_reg <= '0;
        idx_reg <= '0;
      end
      if (rx_done_tick_i) begin
        case (state_reg)
          S_LEN2: len_reg[23:16] <= rx_data_i;
          S_LEN1: len_reg[15:8]  <= rx_data_i;
          S_LEN0: len_reg[7:0]   <= rx_data_i;
          S_DATA: begin
            mem_we_reg   <= 1'b1;
            mem_addr_reg <= idx_reg[ADDR_W-1:0];
            mem_dout_reg <= rx_data_i;
            sum_reg      <= sum_reg + rx_data_i;
            idx_reg      <= idx_reg + 24'd1;
          end
          default: ;
        endcase
      end
      // Oversize length and checksum both land here; only a matching checksum ACKs.
      if (enter_resp) begin
        tx_start_reg <= 1'b1;
        tx_din_reg   <= resp_ack ? ACK : NAK;
        ack_reg      <= resp_ack;
        boot_err_reg <= !resp_ack;
      end
      if (timeout_fire) begin
        boot_err_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    disable_core_n = (state_reg == S_RUN);
    tx_din_o       = tx_din_reg;
    tx_start_o     = tx_start_reg;
    uart_mem_we    = mem_we_reg;
    uart_mem_addr  = mem_addr_reg;
    uart_mem_dout  = mem_dout_reg;
    boot_err_o     = boot_err_reg;
  end

endmodule

// File: tb/tb_mystic_boot_ctrl.sv
// Directed bench for mystic_boot_ctrl: good/bad/zero/oversize frames, noise, re-boot,
// reset mid-frame and (with MYSTIC_BOOT_TIMEOUT_EN) the inter-byte timeout.
module tb_mystic_boot_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_done_tick_i = 1'b0;
  logic [7:0]  tx_din_o;
  logic        tx_start_o;
  logic        tx_done_tick_i = 1'b0;
  logic [17:0] uart_mem_addr;
  logic [7:0]  uart_mem_dout;
  logic        uart_mem_we;
  logic        disable_core_n;
  logic        boot_err_o;

  int checks = 0;
  int passed = 0;
  int wr_total = 0;
  int tx_total = 0;
  int overlap_total = 0;
  logic [17:0] wr_addr_log [256];
  logic [7:0]  wr_data_log [256];
  logic [7:0]  tx_byte_last = 8'h00;

  mystic_boot_ctrl #(
    .ADDR_W(18), .MAGIC(8'hA5), .ACK(8'h06), .NAK(8'h15), .TIMEOUT_CYC(100)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_data_i(rx_data_i), .rx_done_tick_i(rx_done_tick_i),
    .tx_din_o(tx_din_o), .tx_start_o(tx_start_o), .tx_done_tick_i(tx_done_tick_i),
    .uart_mem_addr(uart_mem_addr), .uart_mem_dout(uart_mem_dout), .uart_mem_we(uart_mem_we),
    .disable_core_n(disable_core_n), .boot_err_o(boot_err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (uart_mem_we) begin
      wr_addr_log[wr_total[7:0]] <= uart_mem_addr;
      wr_data_log[wr_total[7:0]] <= uart_mem_dout;
      wr_total <= wr_total + 1;
      $display("write addr=%0h data=%02h", uart_mem_addr, uart_mem_dout);
    end
    if (tx_start_o) begin
      tx_byte_last <= tx_din_o;
      tx_total <= tx_total + 1;
      $display("tx byte=%02h", tx_din_o);
    end
    if (uart_mem_we && tx_start_o) overlap_total <= overlap_total + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk_i);
    #1;
    rx_data_i = b;
    rx_done_tick_i = 1'b1;
    $display("rx byte=%02h", b);
    @(posedge clk_i);
    #1;
    rx_done_tick_i = 1'b0;
  endtask

  task automatic wait_tx(input int base, input logic [7:0] exp, input string tag);
    int n = 0;
    while (tx_total == base && n < 200) begin
      tick(1);
      n++;
    end
    chk({tag, "_tx_count"}, 32'(tx_total - base), 32'd1);
    chk({tag, "_tx_byte"}, 32'(tx_byte_last), 32'(exp));
  endtask

  task automatic finish_tx(input logic [7:0] exp, input string tag);
    tick(2);
    chk({tag, "_tx_din_stable"}, 32'(tx_din_o), 32'(exp));
    @(posedge clk_i);
    #1;
    tx_done_tick_i = 1'b1;
    @(posedge clk_i);
    #1;
    tx_done_tick_i = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
  endtask

  initial begin
    int wb;
    int tb0;
    logic [7:0] good_data [4];
    good_data[0] = 8'hAB;
    good_data[1] = 8'hCD;
    good_data[2] = 8'h12;
    good_data[3] = 8'h34;

    // Reset state, sampled while reset is still held.
    tick(3);
    chk("rst_outputs", 32'({tx_start_o, uart_mem_we, disable_core_n, boot_err_o}), 32'd0);
    chk("rst_tx_din", 32'(tx_din_o), 32'd0);
    chk("rst_mem_addr", 32'(uart_mem_addr), 32'd0);
    chk("rst_mem_dout", 32'(uart_mem_dout), 32'd0);
    rst_i = 1'b0;

    // Good frame, plus a stray byte during RESP that must be dropped.
    wb = wr_total;
    tb0 = tx_total;
    send(8'hA5); send(8'h00); send(8'h00); send(8'h04);
    send(8'hAB);
    chk("good_we_t1", 32'(uart_mem_we), 32'd1);
    chk("good_addr_t1", 32'(uart_mem_addr), 32'd0);
    chk("good_dout_t1", 32'(uart_mem_dout), 32'hAB);
    send(8'hCD); send(8'h12); send(8'h34); send(8'hBE);
    wait_tx(tb0, 8'h06, "good");
    chk("good_core_held", 32'(disable_core_n), 32'd0);
    send(8'h55);
    tick(2);
    chk("good_resp_drop_wr", 32'(wr_total - wb), 32'd4);
    chk("good_resp_drop_tx", 32'(tx_total - tb0), 32'd1);
    finish_tx(8'h06, "good");
    chk("good_core_runs", 32'(disable_core_n), 32'd1);
    chk("good_boot_err", 32'(boot_err_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("good_wr_addr", 32'(wr_addr_log[(wb + i) % 256]), 32'(i));
      chk("good_wr_data", 32'(wr_data_log[(wb + i) % 256]), 32'(good_data[i]));
    end

    // Bad checksum: writes still happen, NAK, core stays held.
    pulse_reset();
    wb = wr_total;
    tb0 = tx_total;
    send(8'hA5); send(8'h00); send(8'h00); send(8'h04);
    send(8'hAB); send(8'hCD); send(8'h12); send(8'h34); send(8'hBF);
    wait_tx(tb0, 8'h15, "bad");
    finish_tx(8'h15, "bad");
    chk("bad_wr_count", 32'(wr_total - wb), 32'd4);
    chk("bad_core_held", 32'(disable_core_n), 32'd0);
    chk("bad_boot_err", 32'(boot_err_o), 32'd1);

    // Zero length: straight to checksum, ACK, RUN, no writes.
    wb = wr_total;
    tb0 = tx_total;
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    wait_tx(tb0, 8'h06, "zero");
    finish_tx(8'h06, "zero");
    chk("zero_wr_count", 32'(wr_total - wb), 32'd0);
    chk("zero_core_runs", 32'(disable_core_n), 32'd1);
    chk("zero_boot_err", 32'(boot_err_o), 32'd0);

    // Oversize length from RUN: re-boot, immediate NAK, no writes.
    wb = wr_total;
    tb0 = tx_total;
    send(8'hA5);
    chk("over_core_drop", 32'(disable_core_n), 32'd0);
    send(8'hFF); send(8'hFF); send(8'hFF);
    wait_tx(tb0, 8'h15, "over");
    finish_tx(8'h15, "over");
    chk("over_wr_count", 32'(wr_total - wb), 32'd0);
    chk("over_core_held", 32'(disable_core_n), 32'd0);

    // Noise in IDLE, one-byte frame, then MAGIC in RUN re-boots.
    wb = wr_total;
    tb0 = tx_total;
    send(8'h00); send(8'h11);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h01); send(8'h7F); send(8'h7F);
    wait_tx(tb0, 8'h06, "noise");
    finish_tx(8'h06, "noise");
    chk("noise_wr_count", 32'(wr_total - wb), 32'd1);
    chk("noise_wr_addr", 32'(wr_addr_log[wb % 256]), 32'd0);
    chk("noise_wr_data", 32'(wr_data_log[wb % 256]), 32'h7F);
    chk("noise_core_runs", 32'(disable_core_n), 32'd1);
    send(8'h33);
    chk("run_other_ignored", 32'(disable_core_n), 32'd1);
    send(8'hA5);
    chk("reboot_core_drop", 32'(disable_core_n), 32'd0);

    // Reset after 2 of 4 data bytes, then a clean good frame.
    pulse_reset();
    wb = wr_total;
    tb0 = tx_total;
    send(8'hA5); send(8'h00); send(8'h00); send(8'h04);
    send(8'hAB); send(8'hCD);
    pulse_reset();
    chk("midrst_outputs", 32'({tx_start_o, uart_mem_we, disable_core_n, boot_err_o}), 32'd0);
    chk("midrst_addr_dout", 32'({uart_mem_addr, uart_mem_dout}), 32'd0);
    send(8'h12); send(8'h34); send(8'hBE);
    tick(3);
    chk("midrst_wr_count", 32'(wr_total - wb), 32'd2);
    chk("midrst_tx_count", 32'(tx_total - tb0), 32'd0);
    wb = wr_total;
    send(8'hA5); send(8'h00); send(8'h00); send(8'h04);
    send(8'hAB); send(8'hCD); send(8'h12); send(8'h34); send(8'hBE);
    wait_tx(tb0, 8'h06, "reboot");
    finish_tx(8'h06, "reboot");
    chk("reboot_wr_count", 32'(wr_total - wb), 32'd4);
    chk("reboot_last_addr", 32'(wr_addr_log[(wb + 3) % 256]), 32'd3);
    chk("reboot_core_runs", 32'(disable_core_n), 32'd1);

`ifdef MYSTIC_BOOT_TIMEOUT_EN
    // Stall after A5 00: expect return to IDLE around 100 idle cycles.
    pulse_reset();
    tb0 = tx_total;
    send(8'hA5); send(8'h00);
    tick(95);
    chk("tmo_err_before", 32'(boot_err_o), 32'd0);
    tick(10);
    chk("tmo_err_after", 32'(boot_err_o), 32'd1);
    chk("tmo_no_tx", 32'(tx_total - tb0), 32'd0);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    wait_tx(tb0, 8'h06, "tmo_idle");
    finish_tx(8'h06, "tmo_idle");
    chk("tmo_core_runs", 32'(disable_core_n), 32'd1);
`endif

    chk("no_we_tx_overlap", 32'(overlap_total), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
